// File: rtl/hopfield_update_ctrl.sv
// Hopfield network recall controller: asynchronous in-place neuron updates
// with sequential weight fetch, convergence detection and a sweep limit.
module hopfield_update_ctrl #(
  parameter int unsigned N          = 25,
  parameter int unsigned DW         = 16,
  parameter int unsigned MAX_SWEEPS = 8,
  parameter int unsigned AW         = $clog2(N * N)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [N-1:0]                        init_pattern,
  output logic [AW-1:0]                       w_addr,
  input  logic [DW-1:0]                       w_data,
  output logic                                busy,
  output logic                                done,
  output logic                                converged,
  output logic [$clog2(MAX_SWEEPS+1)-1:0]     sweeps,
  output logic [N-1:0]                        state_out
);

  localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned JW   = $clog2(N + 1);
  localparam int unsigned SW   = $clog2(MAX_SWEEPS + 1);
  localparam int unsigned ACCW = DW + IW + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] ACCUM  = 3'd2;
  localparam logic [2:0] UPDATE = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [AW-1:0]   base_q, base_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            flip_q, flip_d;

  logic [AW-1:0]   addr_d;
  logic            busy_d, done_d, conv_d;
  logic [SW-1:0]   sweeps_d, sweeps_inc;
  logic [N-1:0]    vec_d;

  logic [ACCW-1:0] wext;
  logic [IW-1:0]   jm1;
  logic            upd_bit;

  // Weight sign-extended to accumulator width; j-1 selects the neuron whose
  // weight arrives this cycle (one-cycle read latency).
  assign wext       = {{(ACCW-DW){w_data[DW-1]}}, w_data};
  assign jm1        = IW'(j_q - JW'(1));
  assign sweeps_inc = sweeps + SW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      flip_q    <= 1'b0;
      w_addr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      sweeps    <= '0;
      state_out <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      base_q    <= base_d;
      acc_q     <= acc_d;
      flip_q    <= flip_d;
      w_addr    <= addr_d;
      busy      <= busy_d;
      done      <= done_d;
      converged <= conv_d;
      sweeps    <= sweeps_d;
      state_out <= vec_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    base_d   = base_q;
    acc_d    = acc_q;
    flip_d   = flip_q;
    addr_d   = w_addr;
    busy_d   = busy;
    done_d   = 1'b0;
    conv_d   = converged;
    sweeps_d = sweeps;
    vec_d    = state_out;
    upd_bit  = state_out[i_q];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end

      LOAD: begin
        vec_d    = init_pattern;
        i_d      = '0;
        j_d      = '0;
        base_d   = '0;
        addr_d   = '0;
        acc_d    = '0;
        flip_d   = 1'b0;
        sweeps_d = '0;
        conv_d   = 1'b0;
        state_d  = ACCUM;
      end

      // Issue addresses on j=0..N-1, accumulate the returning data on j=1..N.
      ACCUM: begin
        if (j_q != '0) begin
          acc_d = state_out[jm1] ? (acc_q + wext) : (acc_q - wext);
        end
        if (j_q == JW'(N)) begin
          j_d     = '0;
          state_d = UPDATE;
        end else begin
          j_d    = j_q + JW'(1);
          addr_d = (j_q == JW'(N - 1)) ? '0 : (w_addr + AW'(1));
        end
      end

      UPDATE: begin
        if (acc_q[ACCW-1]) begin
          upd_bit = 1'b0;
        end else if (acc_q != '0) begin
          upd_bit = 1'b1;
        end
        vec_d[i_q] = upd_bit;
        if (upd_bit != state_out[i_q]) begin
          flip_d = 1'b1;
        end
        acc_d = '0;
        if (i_q == IW'(N - 1)) begin
          state_d = CHECK;
        end else begin
          i_d     = i_q + IW'(1);
          base_d  = base_q + AW'(N);
          addr_d  = base_q + AW'(N);
          state_d = ACCUM;
        end
      end

      CHECK: begin
        sweeps_d = sweeps_inc;
        if (!flip_q) begin
          conv_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (sweeps_inc == SW'(MAX_SWEEPS)) begin
          conv_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          i_d     = '0;
          flip_d  = 1'b0;
          base_d  = '0;
          addr_d  = '0;
          state_d = ACCUM;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
